// File: rtl/mips16_mc_ctrl.sv
// Multi-cycle control sequencer for the 16-bit MIPS datapath.
// Walks each instruction through fetch/decode/execute/memory/write-back and runs the memory req/ack watchdog.
module mips16_mc_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [3:0] state,
  output logic       illegal,
  output logic       timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_J    = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_R     = 4'd7,
    S_WB_I     = 4'd8,
    S_WB_LW    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  state_t        st;
  logic [CW-1:0] wait_cnt;
  logic [3:0]    op_q;
  logic          illegal_q;
  logic          timeout_q;
  logic          req_state;
  logic          wd_expire;

  assign req_state = (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
  // An ack in the cycle the count would reach TIMEOUT wins over the watchdog.
  assign wd_expire = req_state && !mem_ack && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_FETCH;
      wait_cnt  <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // Count is only nonzero while stalled, so clearing whenever not stalled
      // also clears it on every entry to a requesting state.
      if (req_state && !mem_ack) begin
        if (wait_cnt != CW'(TIMEOUT))
          wait_cnt <= wait_cnt + CW'(1);
      end else begin
        wait_cnt <= '0;
      end

      if (wd_expire) begin
        st        <= S_HALT;
        timeout_q <= 1'b1;
      end else begin
        case (st)
          S_FETCH:    if (mem_ack) st <= S_DECODE;
          S_DECODE: begin
            op_q <= opcode;
            case (opcode)
              OP_R:          st <= S_EXEC_R;
              OP_ADDI:       st <= S_EXEC_I;
              OP_LW, OP_SW:  st <= S_MEM_ADDR;
              OP_BEQ:        st <= S_BRANCH;
              OP_J:          st <= S_JUMP;
              OP_HALT:       st <= S_HALT;
              default: begin
                st        <= S_HALT;
                illegal_q <= 1'b1;
              end
            endcase
          end
          S_EXEC_R:   st <= S_WB_R;
          S_EXEC_I:   st <= S_WB_I;
          S_MEM_ADDR: st <= (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
          S_MEM_RD:   if (mem_ack) st <= S_WB_LW;
          S_MEM_WR:   if (mem_ack) st <= S_FETCH;
          S_WB_R, S_WB_I, S_WB_LW, S_BRANCH, S_JUMP: st <= S_FETCH;
          S_HALT:     st <= S_HALT;
          default:    st <= S_HALT;
        endcase
      end
    end
  end

  // Strobes decode straight from the state; FETCH and BRANCH also look at ack/zero.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    if (!rst) begin
      case (st)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ack) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end
        end
        S_DECODE: alu_src_b = 2'b11;
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_EXEC_I, S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        S_WB_R: begin
          reg_we  = 1'b1;
          reg_dst = 1'b1;
        end
        S_WB_I:  reg_we = 1'b1;
        S_WB_LW: begin
          reg_we     = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 2'b01;
          pc_we     = zero;
        end
        S_JUMP: begin
          pc_we  = 1'b1;
          pc_src = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign state   = rst ? 4'd0 : st;
  assign illegal = illegal_q & ~rst;
  assign timeout = timeout_q & ~rst;

endmodule

// File: tb/tb_mips16_mc_ctrl.sv
// Directed bench for mips16_mc_ctrl: per-cycle state, strobe and flag checks against hand-built vectors.
module tb_mips16_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ack;
  logic       mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       reg_we, reg_dst, mem_to_reg;
  logic [3:0] state;
  logic       illegal, timeout;
  logic [14:0] ctl;

  int n_chk = 0;
  int n_err = 0;

  // field order: req we iord ir_we pc_we pc_src a_sel b_sel alu_op reg_we reg_dst mem_to_reg
  localparam logic [14:0] C_FW  = 15'b1_0_0_0_0_00_0_01_00_0_0_0;
  localparam logic [14:0] C_FA  = 15'b1_0_0_1_1_00_0_01_00_0_0_0;
  localparam logic [14:0] C_DEC = 15'b0_0_0_0_0_00_0_11_00_0_0_0;
  localparam logic [14:0] C_ER  = 15'b0_0_0_0_0_00_1_00_10_0_0_0;
  localparam logic [14:0] C_EI  = 15'b0_0_0_0_0_00_1_10_00_0_0_0;
  localparam logic [14:0] C_MR  = 15'b1_0_1_0_0_00_0_00_00_0_0_0;
  localparam logic [14:0] C_MW  = 15'b1_1_1_0_0_00_0_00_00_0_0_0;
  localparam logic [14:0] C_WR  = 15'b0_0_0_0_0_00_0_00_00_1_1_0;
  localparam logic [14:0] C_WI  = 15'b0_0_0_0_0_00_0_00_00_1_0_0;
  localparam logic [14:0] C_WL  = 15'b0_0_0_0_0_00_0_00_00_1_0_1;
  localparam logic [14:0] C_BT  = 15'b0_0_0_0_1_01_1_00_01_0_0_0;
  localparam logic [14:0] C_BN  = 15'b0_0_0_0_0_01_1_00_01_0_0_0;
  localparam logic [14:0] C_J   = 15'b0_0_0_0_1_10_0_00_00_0_0_0;
  localparam logic [14:0] C_OFF = 15'b0;

  mips16_mc_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state),
    .illegal(illegal), .timeout(timeout)
  );

  assign ctl = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                alu_op, reg_we, reg_dst, mem_to_reg};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock cycle: drive ack, check this cycle's outputs, advance past the edge
  task automatic step(input string tag, input logic ack, input logic [3:0] st,
                      input logic [14:0] c, input logic [1:0] flg);
    mem_ack = ack;
    #1;
    check({tag, "/state"}, 32'(state), 32'(st));
    check({tag, "/ctl"}, 32'(ctl), 32'(c));
    check({tag, "/flags"}, 32'({illegal, timeout}), 32'(flg));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    mem_ack = 1'b0;
    #1;
    check({tag, "/rst_ctl"}, 32'(ctl), 32'(C_OFF));
    check({tag, "/rst_flags"}, 32'({illegal, timeout, state}), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "/rst_ctl2"}, 32'(ctl), 32'(C_OFF));
    check({tag, "/rst_state2"}, 32'(state), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; opcode = 4'h0; zero = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    do_reset("por");

    // R-type, zero wait; ack held high in non-memory states must be ignored
    opcode = 4'b0000;
    step("r_f", 1, 4'd0, C_FA, 2'b00);
    step("r_d", 1, 4'd1, C_DEC, 2'b00);
    step("r_x", 1, 4'd2, C_ER, 2'b00);
    step("r_w", 1, 4'd7, C_WR, 2'b00);

    // LW, 3 wait cycles on MEM_RD; opcode changes after DECODE to prove it is held
    opcode = 4'b0010;
    step("lw_f", 1, 4'd0, C_FA, 2'b00);
    step("lw_d", 0, 4'd1, C_DEC, 2'b00);
    opcode = 4'b0011;
    step("lw_a", 0, 4'd4, C_EI, 2'b00);
    for (int i = 0; i < 3; i++) step("lw_rw", 0, 4'd5, C_MR, 2'b00);
    step("lw_ra", 1, 4'd5, C_MR, 2'b00);
    step("lw_wb", 0, 4'd9, C_WL, 2'b00);

    // SW with one wait cycle
    opcode = 4'b0011;
    step("sw_f", 1, 4'd0, C_FA, 2'b00);
    step("sw_d", 0, 4'd1, C_DEC, 2'b00);
    step("sw_a", 0, 4'd4, C_EI, 2'b00);
    step("sw_ww", 0, 4'd6, C_MW, 2'b00);
    step("sw_wa", 1, 4'd6, C_MW, 2'b00);

    // ADDI with two fetch wait cycles
    opcode = 4'b0001;
    step("ad_fw", 0, 4'd0, C_FW, 2'b00);
    step("ad_fw", 0, 4'd0, C_FW, 2'b00);
    step("ad_f", 1, 4'd0, C_FA, 2'b00);
    step("ad_d", 0, 4'd1, C_DEC, 2'b00);
    step("ad_x", 0, 4'd3, C_EI, 2'b00);
    step("ad_w", 0, 4'd8, C_WI, 2'b00);

    // BEQ taken, then not taken
    opcode = 4'b0100; zero = 1'b1;
    step("bt_f", 1, 4'd0, C_FA, 2'b00);
    step("bt_d", 0, 4'd1, C_DEC, 2'b00);
    step("bt_b", 0, 4'd10, C_BT, 2'b00);
    zero = 1'b0;
    step("bn_f", 1, 4'd0, C_FA, 2'b00);
    step("bn_d", 0, 4'd1, C_DEC, 2'b00);
    step("bn_b", 0, 4'd10, C_BN, 2'b00);

    // J
    opcode = 4'b0101;
    step("j_f", 1, 4'd0, C_FA, 2'b00);
    step("j_d", 0, 4'd1, C_DEC, 2'b00);
    step("j_j", 0, 4'd11, C_J, 2'b00);

    // HALT opcode: halts without flagging illegal
    opcode = 4'b1111;
    step("h_f", 1, 4'd0, C_FA, 2'b00);
    step("h_d", 0, 4'd1, C_DEC, 2'b00);
    step("h_h", 1, 4'd12, C_OFF, 2'b00);
    step("h_h2", 1, 4'd12, C_OFF, 2'b00);
    do_reset("h_rst");

    // illegal opcode 1010
    opcode = 4'b1010;
    step("il_f", 1, 4'd0, C_FA, 2'b00);
    step("il_d", 0, 4'd1, C_DEC, 2'b00);
    step("il_h", 1, 4'd12, C_OFF, 2'b10);
    step("il_h2", 1, 4'd12, C_OFF, 2'b10);
    step("il_h3", 0, 4'd12, C_OFF, 2'b10);
    do_reset("il_rst");
    step("il_post", 0, 4'd0, C_FW, 2'b00);
    do_reset("il_rst2");

    // watchdog: 15 unacked fetch cycles then HALT
    for (int i = 0; i < 15; i++) step("to_wait", 0, 4'd0, C_FW, 2'b00);
    step("to_halt", 1, 4'd12, C_OFF, 2'b01);
    step("to_halt2", 0, 4'd12, C_OFF, 2'b01);
    do_reset("to_rst");

    // ack on the 15th cycle is honoured
    opcode = 4'b0000;
    for (int i = 0; i < 14; i++) step("t15_wait", 0, 4'd0, C_FW, 2'b00);
    step("t15_ack", 1, 4'd0, C_FA, 2'b00);
    step("t15_dec", 0, 4'd1, C_DEC, 2'b00);
    do_reset("t15_rst");

    // counter clears between FETCH and MEM_RD: 10 + 14 waits, no timeout
    opcode = 4'b0010;
    for (int i = 0; i < 10; i++) step("clr_fw", 0, 4'd0, C_FW, 2'b00);
    step("clr_f", 1, 4'd0, C_FA, 2'b00);
    step("clr_d", 0, 4'd1, C_DEC, 2'b00);
    step("clr_a", 0, 4'd4, C_EI, 2'b00);
    for (int i = 0; i < 14; i++) step("clr_rw", 0, 4'd5, C_MR, 2'b00);
    step("clr_ra", 1, 4'd5, C_MR, 2'b00);
    step("clr_wb", 0, 4'd9, C_WL, 2'b00);

    // reset in the middle of a MEM_WR wait
    opcode = 4'b0011;
    step("mr_f", 1, 4'd0, C_FA, 2'b00);
    step("mr_d", 0, 4'd1, C_DEC, 2'b00);
    step("mr_a", 0, 4'd4, C_EI, 2'b00);
    step("mr_ww", 0, 4'd6, C_MW, 2'b00);
    step("mr_ww2", 0, 4'd6, C_MW, 2'b00);
    do_reset("mr_rst");
    step("mr_post", 0, 4'd0, C_FW, 2'b00);
    step("mr_post2", 1, 4'd0, C_FA, 2'b00);
    step("mr_dec", 0, 4'd1, C_DEC, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
